// File: rtl/mat_load_seq.sv
// Operand-fetch sequencer: streams one input-row vector and one coefficient-column
// vector into the ALU operand registers and tracks the row/column of the product.
module mat_load_seq #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int RAM_AW = $clog2(ROWS*DEPTH),
   parameter int ROM_AW = $clog2(COLS*DEPTH),
   parameter int IW     = $clog2(DEPTH),
   parameter int RW     = $clog2(ROWS),
   parameter int CW     = $clog2(COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              clear,
   output logic              ram_en,
   output logic [RAM_AW-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_rdata,
   output logic              ld_valid,
   output logic [IW-1:0]     ld_idx,
   output logic [DATA_W-1:0] ld_a,
   output logic [DATA_W-1:0] ld_b,
   output logic              load_done,
   output logic [RW-1:0]     row_idx,
   output logic [CW-1:0]     col_idx,
   output logic              frame_done
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, WAIT_LOW} state_t;

   localparam logic [IW-1:0] K_LAST = IW'(DEPTH - 1);

   state_t              state;
   logic [IW-1:0]       k;
   logic [RAM_AW-1:0]   row_base;
   logic [ROM_AW-1:0]   col_base;
   logic                last_row;
   logic                last_col;

   assign row_base = RAM_AW'(DEPTH * row_idx);
   assign col_base = ROM_AW'(DEPTH * col_idx);
   assign last_row = (row_idx == RW'(ROWS - 1));
   assign last_col = (col_idx == CW'(COLS - 1));

   // Memory read data is only meaningful on the cycle the operand strobe is up.
   assign ld_a = ld_valid ? ram_rdata : '0;
   assign ld_b = ld_valid ? rom_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         k          <= '0;
         ram_en     <= 1'b0;
         ram_addr   <= '0;
         rom_addr   <= '0;
         ld_valid   <= 1'b0;
         ld_idx     <= '0;
         load_done  <= 1'b0;
         frame_done <= 1'b0;
         row_idx    <= '0;
         col_idx    <= '0;
      end else if (clear) begin
         state      <= IDLE;
         k          <= '0;
         ram_en     <= 1'b0;
         ram_addr   <= '0;
         rom_addr   <= '0;
         ld_valid   <= 1'b0;
         ld_idx     <= '0;
         load_done  <= 1'b0;
         frame_done <= 1'b0;
         row_idx    <= '0;
         col_idx    <= '0;
      end else begin
         // NOTE: non-blocking assignments, so ld_valid/ld_idx capture the
         // pre-edge ram_en/k and form the one-cycle read-latency pipeline.
         ld_valid <= ram_en;
         ld_idx   <= k;

         unique case (state)
            IDLE: begin
               if (load_en) begin
                  state    <= READ;
                  ram_en   <= 1'b1;
                  ram_addr <= row_base;
                  rom_addr <= col_base;
               end
            end

            READ: begin
               if (k == K_LAST) begin
                  state    <= DRAIN;
                  k        <= '0;
                  ram_en   <= 1'b0;
                  ram_addr <= '0;
                  rom_addr <= '0;
               end else begin
                  k        <= k + IW'(1);
                  ram_addr <= ram_addr + RAM_AW'(1);
                  rom_addr <= rom_addr + ROM_AW'(1);
               end
            end

            DRAIN: begin
               state      <= DONE;
               load_done  <= 1'b1;
               frame_done <= last_row && last_col;
            end

            DONE: begin
               state      <= WAIT_LOW;
               load_done  <= 1'b0;
               frame_done <= 1'b0;
               if (last_col) begin
                  col_idx <= '0;
                  row_idx <= last_row ? '0 : row_idx + RW'(1);
               end else begin
                  col_idx <= col_idx + CW'(1);
               end
            end

            // Blocks a second load while the controller is still in its load state.
            WAIT_LOW: begin
               if (!load_en) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mat_load_seq.md
# mat_load_seq

Operand-fetch sequencer for the matrix-multiply datapath. When the controller enters its load state, this block streams one DEPTH-long input-row vector from the input RAM and one DEPTH-long coefficient-column vector from the coefficient ROM into the ALU operand registers. It then pulses `load_done` back to the controller. It keeps the row/column position of the current product so the result can be written to the right place, and flags the end of a full matrix.

## Interface
- `DATA_W`, 8: width of one matrix element.
- `DEPTH`, 8: elements per dot product; equals the controller's shift count.
- `ROWS`, 4: rows of the input matrix.
- `COLS`, 4: columns of the coefficient matrix.
- Derived: `RAM_AW = clog2(ROWS*DEPTH)`, `ROM_AW = clog2(COLS*DEPTH)`, `IW = clog2(DEPTH)`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `load_en`, in, 1: controller is in its load state.
- `clear`, in, 1: synchronous restart of position counters.
- `ram_en`, out, 1: input RAM read enable.
- `ram_addr`, out, RAM_AW: input RAM address.
- `ram_rdata`, in, DATA_W: read data, valid 1 cycle after `ram_en`.
- `rom_addr`, out, ROM_AW: coefficient ROM address; read under `ram_en`, same 1-cycle latency.
- `rom_rdata`, in, DATA_W: coefficient data.
- `ld_valid`, out, 1: operand write strobe to the ALU.
- `ld_idx`, out, IW: operand slot being written.
- `ld_a`, out, DATA_W: input element.
- `ld_b`, out, DATA_W: coefficient element.
- `load_done`, out, 1: one-cycle pulse, vectors complete.
- `row_idx`, out, clog2(ROWS): row of the product being loaded.
- `col_idx`, out, clog2(COLS): column of the product being loaded.
- `frame_done`, out, 1: one-cycle pulse on the last product of the matrix.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE, WAIT_LOW.
- IDLE: go to READ when `load_en` is 1; the element counter k is 0.
- READ: `ram_en`=1; `ram_addr = row_idx*DEPTH + k`; `rom_addr = col_idx*DEPTH + k`; k increments each cycle. After the k=DEPTH-1 issue, go to DRAIN.
- Read pipeline: `ld_valid` and `ld_idx` are `ram_en` and k delayed one cycle. `ld_a`/`ld_b` pass `ram_rdata`/`rom_rdata` straight through while `ld_valid` is 1.
- DRAIN: one cycle; the last element (`ld_idx`=DEPTH-1) is presented. Go to DONE.
- DONE: `load_done`=1 for one cycle, then advance the position:
  - `col_idx` increments.
  - At COLS-1, `col_idx` wraps to 0 and `row_idx` increments.
  - At ROWS-1 with COLS-1, both wrap to 0 and `frame_done`=1 in the same cycle as `load_done`.
  - Go to WAIT_LOW.
- WAIT_LOW: hold until `load_en`=0, then go to IDLE. This blocks re-triggering while the controller is still leaving its load state.
- `load_en` dropping during READ or DRAIN is ignored; the sequence always completes.
- `clear`=1, any state: next state IDLE, k/`row_idx`/`col_idx` = 0, all strobes 0. No `load_done` is issued for an interrupted sequence. `clear` wins over every other transition.
- Addresses are never outside 0..ROWS*DEPTH-1 and 0..COLS*DEPTH-1.

## Timing
- Reset (async, `rst`=0): state IDLE; every output 0, including both addresses, both indices and all strobes.
- `load_en` is sampled high in IDLE at edge t:
  - READ occupies cycles t+1..t+DEPTH.
  - `ld_valid` is high for cycles t+2..t+DEPTH+1.
  - `load_done` is high in cycle t+DEPTH+2.
  - Total latency is DEPTH+2 cycles (10 at DEPTH=8).
- `row_idx`/`col_idx` are stable from IDLE through DONE and update on the edge that leaves DONE.
- `ram_en` is high for exactly DEPTH consecutive cycles per load; `ld_idx` runs 0..DEPTH-1 in order with no gaps.
- Minimum load-to-load gap: WAIT_LOW plus IDLE, so a new READ starts at the earliest 2 cycles after `load_en` goes low.

## Test plan
- Single load, reset state, DEPTH=8: `load_en` rises → `ram_addr` 0..7 and `rom_addr` 0..7 on cycles 1..8; `ld_idx` 0..7 on cycles 2..9; `load_done` on cycle 10 only; `col_idx` becomes 1.
- Column wrap: 4 loads (`load_en` dropped after each `load_done`) → 4th load uses `rom_addr` 24..31; then `col_idx`=0 and `row_idx`=1; the 5th load uses `ram_addr` 8..15.
- Frame wrap: 16 loads → `frame_done`=1 together with `load_done` only on the 16th; both indices return to 0.
- `load_en` held high for 30 cycles: exactly one `load_done`; no second READ until `load_en` has been low for one cycle.
- `clear` during READ at k=3: `ram_en` drops the next cycle, no `load_done`, indices are 0; the next `load_en` restarts at address 0.
- Reset asserted during READ: all outputs 0 immediately. After release with `load_en` high, a full 10-cycle load runs from address 0.
